// File: rtl/e203_nice_accel.sv
// NICE coprocessor: accumulator with clear, iterative shift-add MAC, popcount and read-back.
// One custom-0 instruction in flight; the response is held until the core accepts it.
module e203_nice_accel #(
   parameter int XLEN    = 32,
   parameter int MAC_CYC = XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            nice_req_valid,
   output logic            nice_req_ready,
   input  logic [XLEN-1:0] nice_req_instr,
   input  logic [XLEN-1:0] nice_req_rs1,
   input  logic [XLEN-1:0] nice_req_rs2,
   output logic            nice_rsp_multicyc_valid,
   input  logic            nice_rsp_multicyc_ready,
   output logic [XLEN-1:0] nice_rsp_multicyc_dat,
   output logic            nice_rsp_multicyc_err,
   output logic            nice_active
);

   localparam int         CW          = $clog2(MAC_CYC);
   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   typedef enum logic [1:0] {IDLE, EXEC, RSP} state_t;
   typedef enum logic [2:0] {OP_CLR, OP_MAC, OP_POPCNT, OP_RDACC, OP_ERR} op_t;

   state_t          state, state_nxt;
   op_t             op_dec, op_q;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] acc, dat, rs1_q;
   logic [XLEN-1:0] prod, mcand, mplier, prod_step;
   logic            err;
   logic            req_hsk, last_exec;
   logic            unused_instr;

   function automatic logic [XLEN-1:0] popcount(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] n;
      n = '0;
      for (int i = 0; i < XLEN; i++) n = n + XLEN'(v[i]);
      return n;
   endfunction

   // Bits between the opcode and funct7 carry no meaning for this accelerator.
   assign unused_instr = ^nice_req_instr[24:7];

   always_comb begin
      op_dec = OP_ERR;
      if (nice_req_instr[6:0] == OPC_CUSTOM0) begin
         case (nice_req_instr[31:25])
            7'd0:    op_dec = OP_CLR;
            7'd1:    op_dec = OP_MAC;
            7'd2:    op_dec = OP_POPCNT;
            7'd3:    op_dec = OP_RDACC;
            default: op_dec = OP_ERR;
         endcase
      end
   end

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt               = state;
      nice_req_ready          = 1'b0;
      nice_rsp_multicyc_valid = 1'b0;
      case (state)
         IDLE: begin
            nice_req_ready = 1'b1;
            if (nice_req_valid) state_nxt = EXEC;
         end
         EXEC: begin
            if (cnt == '0) state_nxt = RSP;
         end
         RSP: begin
            nice_rsp_multicyc_valid = 1'b1;
            if (nice_rsp_multicyc_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_hsk     = (state == IDLE) && nice_req_valid;
   assign last_exec   = (state == EXEC) && (cnt == '0);
   assign nice_active = (state != IDLE);
   assign prod_step   = prod + (mplier[0] ? mcand : '0);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
         dat <= '0;
         err <= 1'b0;
      end else begin
         if (req_hsk)
            cnt <= (op_dec == OP_MAC) ? CW'(MAC_CYC - 1) : '0;
         else if ((state == EXEC) && (cnt != '0))
            cnt <= cnt - 1'b1;

         if (last_exec) begin
            err <= (op_q == OP_ERR);
            case (op_q)
               OP_CLR: begin
                  acc <= '0;
                  dat <= '0;
               end
               OP_MAC: begin
                  acc <= acc + prod_step;
                  dat <= acc + prod_step;
               end
               OP_POPCNT: dat <= popcount(rs1_q);
               OP_RDACC:  dat <= acc;
               default:   dat <= '0;
            endcase
         end
      end
   end

   // NOTE: operand and shift-add registers are loaded on every accepted request before use, so they carry no reset.
   always_ff @(posedge clk) begin
      if (req_hsk) begin
         op_q   <= op_dec;
         rs1_q  <= nice_req_rs1;
         prod   <= '0;
         mcand  <= nice_req_rs1;
         mplier <= nice_req_rs2;
      end else if (state == EXEC) begin
         prod   <= prod_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

   assign nice_rsp_multicyc_dat = dat;
   assign nice_rsp_multicyc_err = err;

endmodule
